// File: rtl/mtm_alu_tx_ctrl_pkg.sv
// Shared types and constants for the transmit-side frame scheduler.
// A queue entry is {is_err, C[31:0], flag[3:0], crc[2:0]}; error entries keep err_flag in the low 6 bits.
package mtm_alu_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int ENTRY_W   = 40;
  localparam int ERR_BIT   = 39;
  localparam int C_LSB     = 7;
  localparam int FLAG_LSB  = 3;
  localparam int CRC_LSB   = 0;
  localparam int EFLAG_LSB = 0;

  localparam int DEF_DATA_FRAME_CYC = 58;
  localparam int DEF_ERR_FRAME_CYC  = 14;
  localparam int HOLD_CNT_W         = 16;

  function automatic logic [ENTRY_W-1:0] pack_result(input logic [31:0] c,
                                                     input logic [3:0]  flag,
                                                     input logic [2:0]  crc);
    return {1'b0, c, flag, crc};
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_error(input logic [5:0] eflag);
    return {1'b1, 33'd0, eflag};
  endfunction

endpackage

// File: rtl/mtm_alu_tx_ctrl_if.sv
// Upstream request handshakes (core results, deserializer errors) and the serializer launch bus.
// Handshake: an item transfers on a rising clk edge where valid & ready are both high; valid must hold with stable data until then.
interface mtm_alu_tx_ctrl_if;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_C;
  logic [3:0]  res_flag;
  logic [2:0]  res_crc;
  logic        err_valid;
  logic        err_ready;
  logic [5:0]  err_flag;
  logic        tx_data;
  logic        error_occured;
  logic [31:0] data_C;
  logic [3:0]  data_flag;
  logic [2:0]  data_crc;
  logic [5:0]  error_flag;

  modport master (
    output res_valid, res_C, res_flag, res_crc, err_valid, err_flag,
    input  res_ready, err_ready, tx_data, error_occured,
           data_C, data_flag, data_crc, error_flag
  );

  modport slave (
    input  res_valid, res_C, res_flag, res_crc, err_valid, err_flag,
    output res_ready, err_ready, tx_data, error_occured,
           data_C, data_flag, data_crc, error_flag
  );
endinterface

// File: rtl/mtm_alu_tx_ctrl_tx_fifo.sv
// Small synchronous FIFO with a registered read-data port loaded on pop.
// head_msb peeks the entry type at the head so the launch strobe can be registered in the pop cycle.
module mtm_alu_tx_ctrl_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       head_msb,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          wr_ok;
  logic          rd_ok;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign wr_ok    = wr_en & ~full;
  assign rd_ok    = rd_en & ~empty;
  assign head_msb = mem[rd_ptr][W-1];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/mtm_alu_tx_ctrl.sv
// Transmit scheduler: queues results/errors, launches one serializer frame at a time,
// and blocks the next launch for a fixed holdoff because the serializer has no busy output.
module mtm_alu_tx_ctrl
  import mtm_alu_tx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int DATA_FRAME_CYC = DEF_DATA_FRAME_CYC,
  parameter int ERR_FRAME_CYC  = DEF_ERR_FRAME_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mtm_alu_tx_ctrl_if.slave              bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frames_sent,
  output state_t                        state
);
  state_t                  state_q;
  state_t                  state_d;
  logic                    pop;
  logic                    load;
  logic                    ready_en_q;
  logic                    full;
  logic                    empty;
  logic                    head_is_err;
  logic                    err_ready;
  logic                    res_ready;
  logic                    wr_en;
  logic [ENTRY_W-1:0]      wr_data;
  logic [ENTRY_W-1:0]      rd_data;
  logic                    cur_is_err;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q;
  logic [15:0]             frames_sent_q;
  logic                    tx_data_q;
  logic                    err_strobe_q;

  // Readiness comes only from registered state, so a pop never frees a slot in the same cycle.
  assign err_ready = ready_en_q & ~full;
  assign res_ready = ready_en_q & ~full & ~bus.err_valid;
  assign wr_en     = (bus.err_valid & err_ready) | (bus.res_valid & res_ready);
  assign wr_data   = bus.err_valid ? pack_error(bus.err_flag)
                                   : pack_result(bus.res_C, bus.res_flag, bus.res_crc);

  mtm_alu_tx_ctrl_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .head_msb (head_is_err),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        load    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cur_is_err = rd_data[ERR_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q    <= 1'b0;
      hold_cnt_q    <= '0;
      frames_sent_q <= '0;
      tx_data_q     <= 1'b0;
      err_strobe_q  <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      tx_data_q    <= pop & ~head_is_err;
      err_strobe_q <= pop & head_is_err;
      // Loaded in LAUNCH so the strobe cycle plus HOLD spans exactly FRAME_CYC cycles.
      if (load) begin
        hold_cnt_q    <= cur_is_err ? HOLD_CNT_W'(ERR_FRAME_CYC - 2)
                                    : HOLD_CNT_W'(DATA_FRAME_CYC - 2);
        frames_sent_q <= frames_sent_q + 16'd1;
      end else if (state_q == ST_HOLD && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
    end
  end

  assign bus.err_ready     = err_ready;
  assign bus.res_ready     = res_ready;
  assign bus.tx_data       = tx_data_q;
  assign bus.error_occured = err_strobe_q;
  assign bus.data_C        = cur_is_err ? 32'd0 : rd_data[C_LSB +: 32];
  assign bus.data_flag     = cur_is_err ? 4'd0  : rd_data[FLAG_LSB +: 4];
  assign bus.data_crc      = cur_is_err ? 3'd0  : rd_data[CRC_LSB +: 3];
  assign bus.error_flag    = cur_is_err ? rd_data[EFLAG_LSB +: 6] : 6'd0;

  assign busy        = (state_q != ST_IDLE);
  assign frames_sent = frames_sent_q;
  assign state       = state_q;
endmodule

// File: tb/tb_mtm_alu_tx_ctrl.sv
// Self-checking bench for mtm_alu_tx_ctrl: directed scenarios followed by randomized traffic,
// checked against a queue-based model of launched frames, frame lengths and strobe spacing.
module tb_mtm_alu_tx_ctrl;
  import mtm_alu_tx_ctrl_pkg::*;

  localparam int DATA_CYC = 58;
  localparam int ERR_CYC  = 14;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] frames_sent;
  state_t      dut_state;

  mtm_alu_tx_ctrl_if bus ();

  mtm_alu_tx_ctrl #(.FIFO_DEPTH(4), .DATA_FRAME_CYC(DATA_CYC), .ERR_FRAME_CYC(ERR_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .frames_sent (frames_sent),
    .state       (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // Entry: {is_err, C[31:0], flag[3:0], crc[2:0], err_flag[5:0]}
  logic [45:0]  exp_q[$];
  int unsigned  strobe_cyc[$];
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  model_count = 16'd0;
  int unsigned  acc_cyc;
  int           last_busy_len = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: each strobe must match the next expected frame; busy length and payload hold are checked per frame.
  logic        prev_strobe = 1'b0;
  logic        in_frame = 1'b0;
  logic        changed = 1'b0;
  int          busy_cnt = 0;
  int          frame_len = 0;
  logic [44:0] held;
  logic [45:0] mon_e;
  logic [44:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0;
      in_frame    = 1'b0;
      exp_q.delete();
      model_count = 16'd0;
    end else begin
      if (bus.tx_data | bus.error_occured) begin
        check("no_back_to_back_strobe", prev_strobe, 1'b0);
        check("single_strobe", bus.tx_data & bus.error_occured, 1'b0);
        check("busy_at_strobe", busy, 1'b1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_strobe: observed=strobe expected=none");
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_kind", bus.error_occured, mon_e[45]);
          mon_exp = mon_e[45] ? {39'd0, mon_e[5:0]} : {mon_e[44:6], 6'd0};
          check("payload", {bus.data_C, bus.data_flag, bus.data_crc, bus.error_flag}, mon_exp);
          frame_len = mon_e[45] ? ERR_CYC : DATA_CYC;
        end
        held        = {bus.data_C, bus.data_flag, bus.data_crc, bus.error_flag};
        changed     = 1'b0;
        busy_cnt    = 0;
        in_frame    = 1'b1;
        model_count = model_count + 16'd1;
        strobe_cyc.push_back(cyc);
      end else if (prev_strobe) begin
        check("frames_sent", frames_sent, model_count);
      end
      if (in_frame) begin
        if (busy) begin
          busy_cnt++;
          if ({bus.data_C, bus.data_flag, bus.data_crc, bus.error_flag} !== held) changed = 1'b1;
        end else begin
          check("busy_len", busy_cnt, frame_len);
          check("payload_hold", changed, 1'b0);
          last_busy_len = busy_cnt;
          in_frame = 1'b0;
        end
      end
      prev_strobe = bus.tx_data | bus.error_occured;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit e, input bit r, input logic [5:0] ef,
                      input logic [31:0] c, input logic [3:0] f, input logic [2:0] crc);
    bit pe = e;
    bit pr = r;
    int n  = 0;
    bus.err_flag = ef; bus.res_C = c; bus.res_flag = f; bus.res_crc = crc;
    while ((pe || pr) && n < 2000) begin
      @(negedge clk);
      bus.err_valid = pe;
      bus.res_valid = pr;
      #1;
      if (pe && bus.err_ready) begin
        exp_q.push_back({1'b1, 32'd0, 4'd0, 3'd0, ef});
        acc_cyc = cyc;
        if (pr) check("arb_res_ready_low", bus.res_ready, 1'b0);
        pe = 1'b0;
      end else if (pr && bus.res_ready) begin
        exp_q.push_back({1'b0, c, f, crc, 6'd0});
        acc_cyc = cyc;
        pr = 1'b0;
      end
      n++;
    end
    if (pe || pr) begin
      checks++; errors++;
      $error("FAIL send_timeout: observed=not_accepted expected=accepted");
    end
    @(posedge clk);
    #1;
    bus.err_valid = 1'b0;
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    if (n >= budget) begin
      checks++; errors++;
      $error("FAIL drain_timeout: observed=pending=%0d expected=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.res_valid = 1'b1; bus.err_valid = 1'b0;
    bus.res_C = 32'hDEADBEEF; bus.res_flag = 4'h0; bus.res_crc = 3'h0; bus.err_flag = 6'h0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst_res_ready", bus.res_ready, 1'b0);
    check("rst_err_ready", bus.err_ready, 1'b0);
    check("rst_tx_data", bus.tx_data, 1'b0);
    check("rst_error_occured", bus.error_occured, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frames_sent", frames_sent, 16'd0);
    check("rst_fifo_level", fifo_level, 3'd0);
    check("rst_state", dut_state, ST_IDLE);
    check("rst_data_C", bus.data_C, 32'd0);
    bus.res_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_res_ready", bus.res_ready, 1'b1);
    check("post_rst_err_ready", bus.err_ready, 1'b1);

    // Single result frame
    strobe_cyc.delete();
    send(1'b0, 1'b1, 6'd0, 32'h12345678, 4'b0010, 3'b101);
    wait_done(500);
    check("single_strobe_latency", strobe_cyc.size() == 1 ? strobe_cyc[0] - acc_cyc : 0, 2);
    check("single_busy_len", last_busy_len, DATA_CYC);
    check("single_data_C_held", bus.data_C, 32'h12345678);
    check("single_frames_sent", frames_sent, 16'd1);

    // Simultaneous error and result: error wins, result follows ERR_CYC+1 later
    strobe_cyc.delete();
    send(1'b1, 1'b1, 6'b100100, 32'hCAFEF00D, 4'b1001, 3'b011);
    wait_done(500);
    check("err_first_count", strobe_cyc.size(), 2);
    check("err_then_data_spacing", strobe_cyc.size() == 2 ? strobe_cyc[1] - strobe_cyc[0] : 0, ERR_CYC + 1);

    // Five results queued behind a busy serializer
    strobe_cyc.delete();
    send(1'b0, 1'b1, 6'd0, 32'hA0000000, 4'h1, 3'h1);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 6'd0, 32'hB0000000 + i, 4'(i), 3'(i));
    @(negedge clk);
    bus.res_C = 32'hB0000004; bus.res_flag = 4'h4; bus.res_crc = 3'h4;
    bus.res_valid = 1'b1;
    #1;
    check("full_res_ready", bus.res_ready, 1'b0);
    check("full_fifo_level", fifo_level, 3'd4);
    send(1'b0, 1'b1, 6'd0, 32'hB0000004, 4'h4, 3'h4);
    wait_done(2000);
    check("five_strobe_count", strobe_cyc.size(), 6);
    for (int i = 1; i < 6; i++)
      check("queued_spacing", strobe_cyc.size() == 6 ? strobe_cyc[i] - strobe_cyc[i-1] : 0, DATA_CYC + 1);

    // Reset in the middle of HOLD with one entry still queued
    strobe_cyc.delete();
    send(1'b0, 1'b1, 6'd0, 32'h55AA55AA, 4'h5, 3'h2);
    send(1'b0, 1'b1, 6'd0, 32'h66BB66BB, 4'h6, 3'h3);
    begin
      int n = 0;
      while (strobe_cyc.size() == 0 && n < 100) begin @(negedge clk); n++; end
    end
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_fifo_level", fifo_level, 3'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_fifo_level", fifo_level, 3'd0);
    check("midrst_frames_sent", frames_sent, 16'd0);
    check("midrst_strobes", {bus.tx_data, bus.error_occured}, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    strobe_cyc.delete();
    repeat (100) @(negedge clk);
    check("no_strobe_after_rst", strobe_cyc.size(), 0);
    check("idle_after_rst", dut_state, ST_IDLE);

    // frames_sent wrap
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    model_count = 16'hFFFF;
    @(negedge clk);
    check("forced_frames_sent", frames_sent, 16'hFFFF);
    send(1'b1, 1'b0, 6'b010101, 32'd0, 4'd0, 3'd0);
    wait_done(500);
    check("frames_sent_wrap", frames_sent, 16'h0000);

    // Randomized mix of results, errors and simultaneous requests
    for (int i = 0; i < 24; i++) begin
      int kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(kind != 0, kind != 1, 6'($urandom), $urandom, 4'($urandom), 3'($urandom));
    end
    wait_done(5000);
    check("random_drained", exp_q.size(), 0);
    check("random_frames_sent", frames_sent, model_count);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mtm_alu_tx_ctrl.md
Name: mtm_Alu_tx_ctrl

Overview:
Transmit-side scheduler placed between mtm_Alu_core / mtm_Alu_deserializer and mtm_Alu_serializer. It accepts result frames from the core and error reports from the deserializer over valid/ready handshakes and queues them in a small FIFO. It launches one serializer frame at a time: a one-cycle tx_data or error_occured strobe, with the payload held stable for the whole frame. It gates the next launch with a holdoff counter sized to the serializer frame duration, because the serializer has no busy output.

Parameters:
FIFO_DEPTH, 4, queue entries; power of two, 2..16
DATA_FRAME_CYC, 58, cycles reserved per data frame, strobe cycle included (55 bits plus serializer state overhead and margin)
ERR_FRAME_CYC, 14, cycles reserved per error frame, strobe cycle included (11 bits plus overhead and margin)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
res_valid  in  1  core result available
res_ready  out  1  result accepted when res_valid & res_ready
res_C  in  32  result data
res_flag  in  4  result flags
res_crc  in  3  result CRC
err_valid  in  1  error report available
err_ready  out  1  error accepted when err_valid & err_ready
err_flag  in  6  error flags
tx_data  out  1  one-cycle data-frame launch strobe to serializer
error_occured  out  1  one-cycle error-frame launch strobe to serializer
data_C  out  32  held payload to serializer
data_flag  out  4  held payload to serializer
data_crc  out  3  held payload to serializer
error_flag  out  6  held payload to serializer
busy  out  1  frame in flight (LAUNCH or HOLD)
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
frames_sent  out  16  launched-frame counter, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, synchronous release on clk): state IDLE; FIFO empty; all outputs 0; frames_sent 0.
- Enqueue: at most one write per cycle. Entry = {is_err, C[31:0], flag[3:0], crc[2:0]}, 40 bits; an error entry stores err_flag in the low 6 bits and zeros elsewhere.
- Arbitration: error has priority. err_ready = !full; res_ready = !full & !err_valid. A result stalled by a simultaneous error is taken on a later cycle; ready depends on the registered full flag only.
- Pop and enqueue in the same cycle are legal. When full, a pop this cycle does not raise ready this cycle (no bypass).
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the payload registers (data_C/flag/crc, or error_flag with the others zeroed) -> LAUNCH.
  - LAUNCH (1 cycle): exactly one of error_occured/tx_data = 1, chosen by is_err; holdoff counter := FRAME_CYC-2 (ERR or DATA); frames_sent++ -> HOLD.
  - HOLD: counter decrements each cycle; when counter == 0 -> IDLE.
- Timing: strobe-to-strobe spacing for back-to-back queued frames is FRAME_CYC+1 cycles (the IDLE pop cycle adds 1). Strobes are registered outputs and never high two consecutive cycles.
- Payload outputs change only in the IDLE pop cycle and are stable from the strobe through the end of HOLD.
- The serializer checks error_occured before tx_data, but this block never asserts both strobes together.
- Empty FIFO in IDLE: remain IDLE, strobes 0, payload registers hold their last value.
- busy = (state != IDLE).
- Reset mid-frame: all state is cleared immediately, queued entries are discarded, strobes drop to 0.

Decomposition:
- Shared package/include mtm_Alu_pkg: state encodings (IDLE, LAUNCH, HOLD), ENTRY_W = 40, entry field offsets, default frame cycle constants.
- Sub-module mtm_Alu_tx_fifo: synchronous FIFO with wr_en/rd_en, full/empty, level, registered read data, async reset.
- The FSM, arbitration and holdoff counter stay in the top module.

Test Plan:
- Reset with res_valid=1 -> res_ready=0 during reset; after release res_ready=1; all strobes 0; frames_sent=0.
- Single result C=0x12345678, flag=4'b0010, crc=3'b101 -> tx_data high exactly 1 cycle, 2 cycles after acceptance; data_C=0x12345678 stable for 58 cycles; busy high 58 cycles; frames_sent=1.
- Simultaneous err_valid (err_flag=6'b100100) and res_valid -> error accepted first, res_ready=0 that cycle; error_occured strobe first; tx_data strobe follows 15 cycles later (ERR_FRAME_CYC+1).
- Push 5 results with serializer busy, FIFO_DEPTH=4 -> 4 accepted, res_ready=0 and fifo_level=4 while the 5th waits; all 5 launched in order, strobe spacing 59 cycles.
- rst_n asserted at HOLD cycle 20 -> strobes, busy, fifo_level and frames_sent are 0 asynchronously; no strobe after release until a new request arrives.
- Force frames_sent=0xFFFF, launch one frame -> frames_sent=0x0000.
